// File: rtl/note_detector.sv
// note_detector
//   Measures the period of an incoming square-wave tone and decodes which of
//   the eight scale notes C4..C5 is sounding. A note is only reported after
//   STABLE_COUNT consecutive periods agree, and is dropped after a silence of
//   MAX_PERIOD+1 cycles.
//
// Ports
//   CLK          system clock (100 MHz)
//   RESET        asynchronous reset, active low
//   FREQ_IN      asynchronous square-wave tone input
//   NOTE[3:0]    0 = none, 1 = C4 .. 8 = C5
//   VALID        high while NOTE holds a locked note
//   NOTE_STROBE  one-cycle pulse when NOTE takes a new nonzero value
//   Led[7:0]     one-hot of NOTE, C4 -> Led[7] .. C5 -> Led[0]
//
// State table
//   state     | meaning
//   S_IDLE    | no timing reference; the next rising edge only arms the counter
//   S_ACQUIRE | measuring periods, no note reported yet
//   S_LOCKED  | NOTE/VALID report a note; a new note needs a full match run

module note_detector #(
  parameter int STABLE_COUNT = 4,
  parameter int MIN_PERIOD   = 180000,
  parameter int MAX_PERIOD   = 400000,
  parameter int CNT_W        = 19,
  // Lower period bound of each note band (midpoints between adjacent notes).
  parameter int TH_C4        = 361375,
  parameter int TH_D4        = 321950,
  parameter int TH_E4        = 294857,
  parameter int TH_F4        = 270723,
  parameter int TH_G4        = 241188,
  parameter int TH_A4        = 214876,
  parameter int TH_B4        = 196796
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       FREQ_IN,
  output logic [3:0] NOTE,
  output logic       VALID,
  output logic       NOTE_STROBE,
  output logic [7:0] Led
);

  localparam int MATCH_W = $clog2(STABLE_COUNT + 1);

  localparam logic [CNT_W-1:0]   CNT_SAT = CNT_W'(MAX_PERIOD + 1);
  localparam logic [CNT_W-1:0]   P_MIN   = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0]   P_MAX   = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0]   T_C4    = CNT_W'(TH_C4);
  localparam logic [CNT_W-1:0]   T_D4    = CNT_W'(TH_D4);
  localparam logic [CNT_W-1:0]   T_E4    = CNT_W'(TH_E4);
  localparam logic [CNT_W-1:0]   T_F4    = CNT_W'(TH_F4);
  localparam logic [CNT_W-1:0]   T_G4    = CNT_W'(TH_G4);
  localparam logic [CNT_W-1:0]   T_A4    = CNT_W'(TH_A4);
  localparam logic [CNT_W-1:0]   T_B4    = CNT_W'(TH_B4);
  localparam logic [MATCH_W-1:0] M_FULL  = MATCH_W'(STABLE_COUNT);
  localparam logic [MATCH_W-1:0] M_ONE   = MATCH_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACQUIRE,
    S_LOCKED
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [3:0]         cand, cand_n;
  logic [MATCH_W-1:0] match, match_n;
  logic [3:0]         note_n;
  logic               valid_n;
  logic               strobe_n;
  logic [7:0]         led_n;

  logic sync_1, sync_2, sync_prev;
  logic rise;

  logic               in_range;
  logic [3:0]         code;
  logic [3:0]         trk_cand;
  logic [MATCH_W-1:0] trk_match;

  function automatic logic [7:0] led_of(input logic [3:0] n);
    logic [7:0] l;
    l = 8'h00;
    if (n != 4'd0 && n <= 4'd8) l = 8'h80 >> (n - 4'd1);
    return l;
  endfunction

  // Two-flop synchronizer followed by one history flop for edge detection.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_1    <= FREQ_IN;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
    end
  end

  assign rise = sync_2 & ~sync_prev;

  // The counter value at a detected edge is the period just completed.
  always_comb begin
    in_range = (cnt >= P_MIN) && (cnt <= P_MAX);
    if      (cnt >= T_C4) code = 4'd1;
    else if (cnt >= T_D4) code = 4'd2;
    else if (cnt >= T_E4) code = 4'd3;
    else if (cnt >= T_F4) code = 4'd4;
    else if (cnt >= T_G4) code = 4'd5;
    else if (cnt >= T_A4) code = 4'd6;
    else if (cnt >= T_B4) code = 4'd7;
    else                  code = 4'd8;
  end

  always_comb begin
    trk_cand  = 4'd0;
    trk_match = '0;
    if (in_range) begin
      if (code == cand) begin
        trk_cand  = cand;
        trk_match = (match >= M_FULL) ? M_FULL : match + M_ONE;
      end else begin
        trk_cand  = code;
        trk_match = M_ONE;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= S_IDLE;
      cnt         <= '0;
      cand        <= 4'd0;
      match       <= '0;
      NOTE        <= 4'd0;
      VALID       <= 1'b0;
      NOTE_STROBE <= 1'b0;
      Led         <= 8'h00;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      cand        <= cand_n;
      match       <= match_n;
      NOTE        <= note_n;
      VALID       <= valid_n;
      NOTE_STROBE <= strobe_n;
      Led         <= led_n;
    end
  end

  always_comb begin
    state_n  = state;
    cand_n   = cand;
    match_n  = match;
    note_n   = NOTE;
    valid_n  = VALID;
    strobe_n = 1'b0;

    // Saturating period counter; reloads to 1 on the edge cycle itself.
    if (rise)                cnt_n = {{(CNT_W-1){1'b0}}, 1'b1};
    else if (cnt != CNT_SAT) cnt_n = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    else                     cnt_n = cnt;

    unique case (state)
      S_IDLE: begin
        if (rise) begin
          state_n = S_ACQUIRE;
          cand_n  = 4'd0;
          match_n = '0;
        end
      end

      S_ACQUIRE: begin
        if (rise) begin
          cand_n  = trk_cand;
          match_n = trk_match;
          if (trk_match == M_FULL) begin
            state_n  = S_LOCKED;
            note_n   = trk_cand;
            valid_n  = 1'b1;
            strobe_n = 1'b1;
          end
        end else if (cnt == CNT_SAT) begin
          state_n = S_IDLE;
          cand_n  = 4'd0;
          match_n = '0;
          note_n  = 4'd0;
          valid_n = 1'b0;
        end
      end

      S_LOCKED: begin
        if (rise) begin
          cand_n  = trk_cand;
          match_n = trk_match;
          // A run matching the held note just keeps the lock quietly.
          if (trk_match == M_FULL && trk_cand != NOTE) begin
            note_n   = trk_cand;
            strobe_n = 1'b1;
          end
        end else if (cnt == CNT_SAT) begin
          state_n = S_IDLE;
          cand_n  = 4'd0;
          match_n = '0;
          note_n  = 4'd0;
          valid_n = 1'b0;
        end
      end

      default: begin
        state_n = S_IDLE;
        cand_n  = 4'd0;
        match_n = '0;
        note_n  = 4'd0;
        valid_n = 1'b0;
      end
    endcase

    led_n = led_of(note_n);
  end

endmodule

// File: tb/tb_note_detector.sv
// Bench for note_detector with all period constants scaled down by 1000 so the
// run stays short. Expected strobes are queued as stimulus is driven and
// popped by a monitor whenever NOTE_STROBE fires.

module tb_note_detector;

  localparam int MIN_P = 180;
  localparam int MAX_P = 400;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       FREQ_IN;
  logic [3:0] NOTE;
  logic       VALID;
  logic       NOTE_STROBE;
  logic [7:0] Led;

  int         total = 0;
  int         bad = 0;
  int         since_rise = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_note;

  note_detector #(
    .STABLE_COUNT(4),
    .MIN_PERIOD(MIN_P),
    .MAX_PERIOD(MAX_P),
    .CNT_W(9),
    .TH_C4(361),
    .TH_D4(322),
    .TH_E4(295),
    .TH_F4(271),
    .TH_G4(241),
    .TH_A4(215),
    .TH_B4(197)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .FREQ_IN(FREQ_IN),
    .NOTE(NOTE),
    .VALID(VALID),
    .NOTE_STROBE(NOTE_STROBE),
    .Led(Led)
  );

  always #5 CLK = ~CLK;

  // Scoreboard: every strobe must match the oldest queued expected note.
  always @(negedge CLK) begin
    if (RESET === 1'b1 && NOTE_STROBE === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL strobe_unexpected: NOTE=%0d, required no strobe", NOTE);
      end else begin
        exp_note = exp_q.pop_front();
        if (NOTE !== exp_note || VALID !== 1'b1 || Led !== (8'h80 >> (exp_note - 4'd1))) begin
          bad++;
          $display("FAIL strobe_note: NOTE=%0d VALID=%0b Led=%b, required NOTE=%0d VALID=1 Led=%b",
                   NOTE, VALID, Led, exp_note, 8'h80 >> (exp_note - 4'd1));
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(negedge CLK);
    since_rise++;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Next rising edge lands exactly p cycles after the previous one.
  task automatic edge_after(input int p);
    while (since_rise < p / 2) tick();
    FREQ_IN = 1'b0;
    while (since_rise < p) tick();
    FREQ_IN = 1'b1;
    since_rise = 0;
  endtask

  task automatic arm();
    FREQ_IN = 1'b0;
    ticks(4);
    FREQ_IN = 1'b1;
    since_rise = 0;
  endtask

  task automatic go_silent();
    FREQ_IN = 1'b0;
    ticks(MAX_P + 10);
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    FREQ_IN = 1'b0;
    ticks(3);
    total++;
    if ({NOTE, VALID, NOTE_STROBE, Led} !== 14'd0) begin
      bad++;
      $display("FAIL reset_outputs: NOTE=%0d VALID=%0b STROBE=%0b Led=%b, required all 0",
               NOTE, VALID, NOTE_STROBE, Led);
    end
    RESET = 1'b1;
    ticks(2);
    total++;
    if ({NOTE, VALID, Led} !== 13'd0) begin
      bad++;
      $display("FAIL post_reset_idle: NOTE=%0d VALID=%0b Led=%b, required all 0", NOTE, VALID, Led);
    end
  endtask

  task automatic test_single_lock();
    arm();
    ticks(3);
    total++;
    if (VALID !== 1'b0) begin
      bad++;
      $display("FAIL arm_valid: VALID=%0b, required 0", VALID);
    end
    for (int i = 0; i < 3; i++) begin
      edge_after(227);
      ticks(3);
      total++;
      if (VALID !== 1'b0 || NOTE !== 4'd0) begin
        bad++;
        $display("FAIL acquire_%0d: VALID=%0b NOTE=%0d, required 0/0", i, VALID, NOTE);
      end
    end
    exp_q.push_back(4'd6);
    edge_after(227);
    ticks(2);
    total++;
    if (NOTE !== 4'd0) begin
      bad++;
      $display("FAIL lock_latency_early: NOTE=%0d, required 0", NOTE);
    end
    tick();
    total++;
    if (NOTE !== 4'd6 || VALID !== 1'b1 || Led !== 8'b0000_0100 || NOTE_STROBE !== 1'b1) begin
      bad++;
      $display("FAIL lock_a4: NOTE=%0d VALID=%0b Led=%b STROBE=%0b, required 6/1/00000100/1",
               NOTE, VALID, Led, NOTE_STROBE);
    end
    tick();
    total++;
    if (NOTE_STROBE !== 1'b0) begin
      bad++;
      $display("FAIL strobe_width: STROBE=%0b, required 0", NOTE_STROBE);
    end
    edge_after(227);
    ticks(3);
    total++;
    if (NOTE !== 4'd6 || NOTE_STROBE !== 1'b0) begin
      bad++;
      $display("FAIL edge6_hold: NOTE=%0d STROBE=%0b, required 6/0", NOTE, NOTE_STROBE);
    end
  endtask

  task automatic test_note_change();
    for (int i = 0; i < 3; i++) begin
      edge_after(191);
      ticks(3);
      total++;
      if (NOTE !== 4'd6 || Led !== 8'b0000_0100 || VALID !== 1'b1) begin
        bad++;
        $display("FAIL change_hold_%0d: NOTE=%0d Led=%b VALID=%0b, required 6/00000100/1",
                 i, NOTE, Led, VALID);
      end
    end
    exp_q.push_back(4'd8);
    edge_after(191);
    ticks(3);
    total++;
    if (NOTE !== 4'd8 || Led !== 8'b0000_0001 || NOTE_STROBE !== 1'b1) begin
      bad++;
      $display("FAIL change_c5: NOTE=%0d Led=%b STROBE=%0b, required 8/00000001/1",
               NOTE, Led, NOTE_STROBE);
    end
  endtask

  task automatic test_silence();
    // Counter is 1 at the detection edge, so timeout shows 401 cycles later.
    FREQ_IN = 1'b0;
    while (since_rise < MAX_P + 3) tick();
    total++;
    if (VALID !== 1'b1 || NOTE !== 4'd8) begin
      bad++;
      $display("FAIL silence_early: VALID=%0b NOTE=%0d, required 1/8", VALID, NOTE);
    end
    tick();
    total++;
    if ({NOTE, VALID, NOTE_STROBE, Led} !== 14'd0) begin
      bad++;
      $display("FAIL silence_timeout: NOTE=%0d VALID=%0b STROBE=%0b Led=%b, required all 0",
               NOTE, VALID, NOTE_STROBE, Led);
    end
    arm();
    ticks(3);
    total++;
    if (VALID !== 1'b0 || NOTE !== 4'd0) begin
      bad++;
      $display("FAIL silence_rearm: VALID=%0b NOTE=%0d, required 0/0", VALID, NOTE);
    end
  endtask

  task automatic test_jitter();
    for (int i = 0; i < 20; i++) begin
      edge_after((i % 2 == 1) ? 255 : 227);
      ticks(3);
      total++;
      if (VALID !== 1'b0 || NOTE !== 4'd0) begin
        bad++;
        $display("FAIL jitter_%0d: VALID=%0b NOTE=%0d, required 0/0", i, VALID, NOTE);
      end
    end
    go_silent();
  endtask

  task automatic test_boundaries();
    arm();
    for (int i = 0; i < 3; i++) edge_after(215);
    exp_q.push_back(4'd6);
    edge_after(215);
    ticks(3);
    total++;
    if (NOTE !== 4'd6 || VALID !== 1'b1) begin
      bad++;
      $display("FAIL bound_a4: NOTE=%0d VALID=%0b, required 6/1", NOTE, VALID);
    end
    for (int i = 0; i < 3; i++) edge_after(214);
    ticks(3);
    total++;
    if (NOTE !== 4'd6) begin
      bad++;
      $display("FAIL bound_hold: NOTE=%0d, required 6", NOTE);
    end
    exp_q.push_back(4'd7);
    edge_after(214);
    ticks(3);
    total++;
    if (NOTE !== 4'd7 || Led !== 8'b0000_0010) begin
      bad++;
      $display("FAIL bound_b4: NOTE=%0d Led=%b, required 7/00000010", NOTE, Led);
    end
    go_silent();
    arm();
    for (int i = 0; i < 6; i++) begin
      edge_after(MIN_P - 1);
      ticks(3);
      total++;
      if (VALID !== 1'b0) begin
        bad++;
        $display("FAIL short_period_%0d: VALID=%0b, required 0", i, VALID);
      end
    end
    for (int i = 0; i < 6; i++) begin
      edge_after(MAX_P + 1);
      ticks(3);
      total++;
      if (VALID !== 1'b0) begin
        bad++;
        $display("FAIL long_period_%0d: VALID=%0b, required 0", i, VALID);
      end
    end
    go_silent();
  endtask

  task automatic test_lock_reset();
    arm();
    for (int i = 0; i < 3; i++) edge_after(227);
    exp_q.push_back(4'd6);
    edge_after(227);
    ticks(3);
    total++;
    if (NOTE !== 4'd6 || VALID !== 1'b1) begin
      bad++;
      $display("FAIL prereset_lock: NOTE=%0d VALID=%0b, required 6/1", NOTE, VALID);
    end
    ticks(50);
    RESET = 1'b0;
    FREQ_IN = 1'b0;
    #1;
    total++;
    if ({NOTE, VALID, NOTE_STROBE, Led} !== 14'd0) begin
      bad++;
      $display("FAIL async_reset: NOTE=%0d VALID=%0b STROBE=%0b Led=%b, required all 0",
               NOTE, VALID, NOTE_STROBE, Led);
    end
    ticks(5);
    RESET = 1'b1;
    arm();
    ticks(3);
    total++;
    if (VALID !== 1'b0) begin
      bad++;
      $display("FAIL reset_arm: VALID=%0b, required 0", VALID);
    end
    for (int i = 0; i < 3; i++) begin
      edge_after(227);
      ticks(3);
      total++;
      if (VALID !== 1'b0) begin
        bad++;
        $display("FAIL relock_early_%0d: VALID=%0b, required 0", i, VALID);
      end
    end
    exp_q.push_back(4'd6);
    edge_after(227);
    ticks(3);
    total++;
    if (NOTE !== 4'd6 || VALID !== 1'b1 || NOTE_STROBE !== 1'b1) begin
      bad++;
      $display("FAIL relock: NOTE=%0d VALID=%0b STROBE=%0b, required 6/1/1", NOTE, VALID, NOTE_STROBE);
    end
  endtask

  task automatic test_glitch();
    edge_after(100);
    ticks(3);
    total++;
    if (NOTE !== 4'd6 || VALID !== 1'b1) begin
      bad++;
      $display("FAIL glitch_short: NOTE=%0d VALID=%0b, required 6/1", NOTE, VALID);
    end
    edge_after(127);
    ticks(3);
    total++;
    if (NOTE !== 4'd6 || VALID !== 1'b1) begin
      bad++;
      $display("FAIL glitch_rest: NOTE=%0d VALID=%0b, required 6/1", NOTE, VALID);
    end
    for (int i = 0; i < 5; i++) begin
      edge_after(227);
      ticks(3);
      total++;
      if (NOTE !== 4'd6 || NOTE_STROBE !== 1'b0) begin
        bad++;
        $display("FAIL glitch_resume_%0d: NOTE=%0d STROBE=%0b, required 6/0", i, NOTE, NOTE_STROBE);
      end
    end
  endtask

  initial begin
    RESET = 1'b0;
    FREQ_IN = 1'b0;
    test_reset();
    test_single_lock();
    test_note_change();
    test_silence();
    test_jitter();
    test_boundaries();
    test_lock_reset();
    test_glitch();
    ticks(5);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_strobes: %0d expected strobes never seen, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
